// File: rtl/reorder_trace_dispatch_pkg.sv
// Shared definitions for the reorder trace dispatcher: FSM state encoding
// and a constant-evaluable ceiling-log2 helper used to size buses.
package reorder_trace_dispatch_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    // Smallest r with (1 << r) >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_trace_dispatch_credit_counter.sv
// Credit counter: tracks IDs outstanding in the downstream reorder queue.
// Saturates at DEPTH on increment and at zero on decrement; a simultaneous
// increment and decrement leaves the count unchanged.
module reorder_credit_counter
    import reorder_trace_dispatch_pkg::*;
#(
    parameter  int DEPTH     = 64,
    localparam int CNT_WIDTH = clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 arsn_i,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 full
);

    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 inc_ok_s;
    logic                 dec_ok_s;

    assign inc_ok_s = inc & (cnt_r != CNT_WIDTH'(DEPTH));
    assign dec_ok_s = dec & (cnt_r != {CNT_WIDTH{1'b0}});

    // Count update with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!arsn_i) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (inc_ok_s && !dec_ok_s) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
        end else if (!inc_ok_s && dec_ok_s) begin
            cnt_r <= cnt_r - CNT_WIDTH'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign full = (cnt_r == CNT_WIDTH'(DEPTH));

endmodule

// File: rtl/reorder_trace_dispatch.sv
// Reorder trace dispatcher: accepts multi-op transactions, dispatches each
// op to an execution queue with zero latency, pushes one ID per transaction
// into the downstream ID queue and flags transaction boundaries / aborts on
// the trace interface. ID credits bound the number of open IDs to DEPTH.
module reorder_trace_dispatch
    import reorder_trace_dispatch_pkg::*;
#(
    parameter  int NUM_QUEUES = 4,
    parameter  int DEPTH      = 64,
    localparam int ID_WIDTH   = clog2(DEPTH),
    localparam int SEL_WIDTH  = clog2(NUM_QUEUES),
    localparam int CNT_WIDTH  = clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  arsn_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [ID_WIDTH-1:0]   op_id_i,
    input  logic [SEL_WIDTH-1:0]  op_sel_i,
    input  logic                  op_last_i,
    input  logic                  abort_i,
    output logic                  issue_valid_o,
    output logic [SEL_WIDTH-1:0]  issue_sel_o,
    input  logic [NUM_QUEUES-1:0] issue_ready_i,
    output logic                  trace_id_push_o,
    output logic [ID_WIDTH-1:0]   trace_id_value_o,
    output logic                  trace_push_o,
    output logic [SEL_WIDTH-1:0]  trace_sel_o,
    output logic                  trace_break_o,
    output logic                  trace_update_o,
    input  logic                  full_i,
    input  logic                  commit_valid_i,
    input  logic                  commit_pull_i,
    output logic                  busy_o
);

    logic [1:0]           state_r;
    logic [ID_WIDTH-1:0]  id_r;
    logic [CNT_WIDTH-1:0] credit_cnt_s;
    logic                 credit_full_s;
    logic                 stall_s;
    logic                 sel_ready_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 id_push_s;

    // An out-of-range credit value cannot be legitimate; stall rather than
    // let more IDs through.
    assign stall_s     = full_i | credit_full_s | (credit_cnt_s > CNT_WIDTH'(DEPTH));
    assign sel_ready_s = (32'(op_sel_i) < NUM_QUEUES) ? issue_ready_i[op_sel_i] : 1'b0;
    assign ready_s     = arsn_i & ~stall_s & sel_ready_s & ~abort_i & (state_r != ST_UPDATE);
    assign accept_s    = op_valid_i & ready_s;
    assign id_push_s   = accept_s & (state_r == ST_IDLE);

    reorder_credit_counter #(
        .DEPTH (DEPTH)
    ) u_credit (
        .clk_i  (clk_i),
        .arsn_i (arsn_i),
        .inc    (id_push_s),
        .dec    (commit_pull_i & commit_valid_i),
        .cnt    (credit_cnt_s),
        .full   (credit_full_s)
    );

    // Transaction FSM and latched transaction ID.
    always_ff @(posedge clk_i) begin
        if (!arsn_i) begin
            state_r <= ST_IDLE;
            id_r    <= {ID_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        id_r    <= op_id_i;
                        state_r <= op_last_i ? ST_IDLE : ST_OPEN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OPEN: begin
                    if (abort_i) begin
                        state_r <= ST_UPDATE;
                    end else if (accept_s && op_last_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_OPEN;
                    end
                end
                ST_UPDATE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency dispatch/trace outputs; everything idles at 0 (buses
    // included) outside an accept or the update cycle, and during reset.
    always_comb begin
        op_ready_o       = 1'b0;
        issue_valid_o    = 1'b0;
        issue_sel_o      = {SEL_WIDTH{1'b0}};
        trace_id_push_o  = 1'b0;
        trace_id_value_o = {ID_WIDTH{1'b0}};
        trace_push_o     = 1'b0;
        trace_sel_o      = {SEL_WIDTH{1'b0}};
        trace_break_o    = 1'b0;
        trace_update_o   = 1'b0;
        busy_o           = 1'b0;
        if (arsn_i) begin
            op_ready_o     = ready_s;
            trace_update_o = (state_r == ST_UPDATE);
            busy_o         = (state_r != ST_IDLE);
            if (accept_s) begin
                issue_valid_o = 1'b1;
                issue_sel_o   = op_sel_i;
                trace_push_o  = 1'b1;
                trace_sel_o   = op_sel_i;
                trace_break_o = op_last_i;
                if (id_push_s) begin
                    trace_id_push_o  = 1'b1;
                    trace_id_value_o = op_id_i;
                end else begin
                    trace_id_push_o  = 1'b0;
                end
            end else begin
                issue_valid_o = 1'b0;
            end
        end else begin
            op_ready_o = 1'b0;
        end
    end

endmodule

// File: doc/reorder_trace_dispatch.md
REORDER_TRACE_DISPATCH -- requirements
Module: reorder_trace_dispatch

Interface
Parameters and ports below are listed one per line; ports are given as name, direction, width, meaning.
REQ-001 SHALL have parameter NUM_QUEUES, default 4, meaning the number of execution/status queues.
REQ-002 SHALL have parameter DEPTH, default 64, meaning the downstream reorder-queue depth and the ID range.
REQ-003 SHALL derive ID_WIDTH = clog2(DEPTH), SEL_WIDTH = clog2(NUM_QUEUES) and CNT_WIDTH = clog2(DEPTH)+1.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port arsn_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have ports op_valid_i (input, 1) and op_ready_o (output, 1): the upstream operation handshake.
REQ-007 SHALL have port op_id_i, input, ID_WIDTH: transaction ID, sampled only on the first op of a transaction.
REQ-008 SHALL have port op_sel_i, input, SEL_WIDTH: target queue of the operation.
REQ-009 SHALL have port op_last_i, input, 1: the operation closes its transaction.
REQ-010 SHALL have port abort_i, input, 1: terminate the open transaction early.
REQ-011 SHALL have ports issue_valid_o (output, 1), issue_sel_o (output, SEL_WIDTH) and issue_ready_i (input, NUM_QUEUES): the dispatch to execution queues.
REQ-012 SHALL have ports trace_id_push_o (output, 1) and trace_id_value_o (output, ID_WIDTH): to the downstream ID queue.
REQ-013 SHALL have ports trace_push_o, trace_sel_o (SEL_WIDTH), trace_break_o and trace_update_o, all outputs: to the downstream trace queues.
REQ-014 SHALL have port full_i, input, 1: the downstream reorder logic is full.
REQ-015 SHALL have ports commit_valid_i and commit_pull_i, inputs, 1 each: observed commit handshake, used for credit return.
REQ-016 SHALL have port busy_o, output, 1: a transaction is open or an update is pending.

Function
REQ-017 SHALL run an FSM with states IDLE, OPEN and UPDATE.
REQ-018 SHALL compute stall = full_i | (credit_cnt == DEPTH).
REQ-019 SHALL drive op_ready_o = ~stall & issue_ready_i[op_sel_i] & ~abort_i & (state != UPDATE), combinationally.
REQ-020 SHALL define accept = op_valid_i & op_ready_o.
REQ-021 On accept, SHALL assert issue_valid_o, trace_push_o and trace_sel_o = op_sel_i, issue_sel_o = op_sel_i and trace_break_o = op_last_i in the same cycle (zero latency).
REQ-022 On accept in IDLE, SHALL also assert trace_id_push_o with trace_id_value_o = op_id_i, latch op_id_i and increment credit_cnt.
REQ-023 On accept in OPEN, SHALL ignore op_id_i and SHALL NOT push an ID.
REQ-024 Transition rules:
- IDLE to OPEN: accept & ~op_last_i.
- IDLE to IDLE: accept & op_last_i (single-op transaction).
- OPEN to IDLE: accept & op_last_i.
REQ-025 abort_i in OPEN SHALL move to UPDATE.
REQ-026 In UPDATE, SHALL assert trace_update_o for exactly one cycle, then return to IDLE.
REQ-027 abort_i in IDLE or UPDATE SHALL be ignored; no output SHALL pulse.
REQ-028 Credit rules:
- credit_cnt SHALL decrement on commit_pull_i & commit_valid_i.
- A simultaneous increment and decrement SHALL leave credit_cnt unchanged.
- credit_cnt SHALL never exceed DEPTH and never underflow; a pull at zero is ignored.
REQ-029 SHALL drive busy_o = (state != IDLE).
REQ-030 Outputs without an accept or UPDATE SHALL be 0, with value buses held at 0.

Reset
REQ-031 SHALL apply reset synchronously while arsn_i is 0:
- state = IDLE, credit_cnt = 0, latched ID = 0;
- all outputs 0, including op_ready_o.
REQ-032 Reset mid-transaction SHALL discard the open transaction with no trace_update_o pulse.

Structure
REQ-033 SHALL place the FSM state encoding and the clog2 helper in a shared reorder package.
REQ-034 SHALL implement the credit counter as sub-module reorder_credit_counter (parameter DEPTH; ports inc, dec, cnt, full).

Verification
REQ-035 Scenario: three ops (sel 0, 2, 1, last on the third) with op_id_i = 5 -> one trace_id_push_o with value 5; three trace_push_o with break pattern 0, 0, 1; credit_cnt = 1.
REQ-036 Scenario: two ops without last, then abort_i -> trace_update_o pulses one cycle later, then IDLE; busy_o = 0.
REQ-037 Scenario: DEPTH single-op transactions with no commits -> op_ready_o = 0 on the (DEPTH+1)th; one commit_pull_i & commit_valid_i -> accepted next cycle.
REQ-038 Scenario: issue_ready_i = 4'b1011 with op_sel_i = 2 -> op_ready_o = 0; change op_sel_i to 3 -> accepted.
REQ-039 Scenario: full_i = 1 while op_valid_i = 1 -> no pushes; full_i = 0 -> accepted in the same cycle.
REQ-040 Scenario: arsn_i low while in OPEN -> IDLE, all outputs 0, no trace_update_o pulse.
